// File: rtl/dcu.sv
// Decryption control unit: latches the block/key pair, requests key expansion, sequences inverse rounds 10..0.
// Latency: start_key_exp the cycle after accept; after key_expanded, 11 round cycles then a 1-cycle de_done pulse.
// Backpressure: start_op is accepted only in IDLE with ed_sel=0; requests while busy are dropped, never queued.
module dcu #(
   parameter int TIMEOUT = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start_op,
   input  logic         ed_sel,
   input  logic         key_op,
   input  logic         key_expanded,
   input  logic [127:0] data_in,
   input  logic [127:0] key_in,
   input  logic [127:0] mk_key,
   output logic [127:0] d_data,
   output logic [127:0] d_key,
   output logic         start_key_exp,
   output logic         round_valid,
   output logic [3:0]   round_idx,
   output logic         busy,
   output logic         de_done,
   output logic         key_err
);

   // Counter is wide enough to hold TIMEOUT itself so the increment on the exit edge never wraps.
   localparam int            CW       = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      KEY_EXP = 2'd1,
      ROUND   = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t         state_q, state_d;
   logic [127:0]   d_data_q, d_data_d;
   logic [127:0]   d_key_q, d_key_d;
   logic [3:0]     round_idx_q, round_idx_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           start_key_exp_q, start_key_exp_d;
   logic           round_valid_q, round_valid_d;
   logic           busy_q, busy_d;
   logic           de_done_q, de_done_d;
   logic           key_err_q, key_err_d;

   // Next-state and next-output logic; every output is computed for the state being entered.
   always_comb begin
      state_d         = state_q;
      d_data_d        = d_data_q;
      d_key_d         = d_key_q;
      round_idx_d     = round_idx_q;
      cnt_d           = cnt_q;
      start_key_exp_d = 1'b0;
      round_valid_d   = 1'b0;
      busy_d          = 1'b0;
      de_done_d       = 1'b0;
      key_err_d       = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_op && !ed_sel) begin
               // Key unwrap runs the wrapped key through the datapath under the master key.
               d_data_d        = key_op ? key_in : data_in;
               d_key_d         = key_op ? mk_key : key_in;
               cnt_d           = '0;
               state_d         = KEY_EXP;
               start_key_exp_d = 1'b1;
               busy_d          = 1'b1;
            end
         end
         KEY_EXP: begin
            cnt_d  = cnt_q + CW'(1);
            busy_d = 1'b1;
            // A schedule arriving on the last allowed edge still wins over the timeout.
            if (key_expanded) begin
               state_d       = ROUND;
               round_idx_d   = 4'd10;
               round_valid_d = 1'b1;
            end else if (cnt_q == CNT_LAST) begin
               state_d   = IDLE;
               key_err_d = 1'b1;
               busy_d    = 1'b0;
            end else begin
               start_key_exp_d = 1'b1;
            end
         end
         ROUND: begin
            busy_d = 1'b1;
            if (round_idx_q == 4'd0) begin
               state_d   = DONE;
               de_done_d = 1'b1;
            end else begin
               round_idx_d   = round_idx_q - 4'd1;
               round_valid_d = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and registered outputs; reset aborts any operation without a done or error pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= IDLE;
         d_data_q        <= '0;
         d_key_q         <= '0;
         round_idx_q     <= '0;
         cnt_q           <= '0;
         start_key_exp_q <= 1'b0;
         round_valid_q   <= 1'b0;
         busy_q          <= 1'b0;
         de_done_q       <= 1'b0;
         key_err_q       <= 1'b0;
      end else begin
         state_q         <= state_d;
         d_data_q        <= d_data_d;
         d_key_q         <= d_key_d;
         round_idx_q     <= round_idx_d;
         cnt_q           <= cnt_d;
         start_key_exp_q <= start_key_exp_d;
         round_valid_q   <= round_valid_d;
         busy_q          <= busy_d;
         de_done_q       <= de_done_d;
         key_err_q       <= key_err_d;
      end
   end

   assign d_data        = d_data_q;
   assign d_key         = d_key_q;
   assign start_key_exp = start_key_exp_q;
   assign round_valid   = round_valid_q;
   assign round_idx     = round_idx_q;
   assign busy          = busy_q;
   assign de_done       = de_done_q;
   assign key_err       = key_err_q;

endmodule
